// File: rtl/prog_clock_divider_if.sv
// Control and status bundle for prog_clock_divider: divisor programming inputs
// and the divided-clock / tick / active-divisor outputs.
interface prog_clock_divider_if #(
    parameter int unsigned WIDTH = 19
);
    // No valid/ready pair here: DIV_LOAD is a single-cycle strobe sampled on the
    // rising clock edge, and DIV_IN only has to be stable during that edge.
    logic             ENABLE;
    logic [WIDTH-1:0] DIV_IN;
    logic             DIV_LOAD;
    logic             DIVIDEDCLK;
    logic             TICK;
    logic [WIDTH-1:0] DIV_ACTIVE;

    modport master (
        output ENABLE,
        output DIV_IN,
        output DIV_LOAD,
        input  DIVIDEDCLK,
        input  TICK,
        input  DIV_ACTIVE
    );

    modport slave (
        input  ENABLE,
        input  DIV_IN,
        input  DIV_LOAD,
        output DIVIDEDCLK,
        output TICK,
        output DIV_ACTIVE
    );
endinterface

// File: rtl/prog_clock_divider.sv
// Programmable synchronous tick/clock-enable divider. Define CLKDIV_IMMEDIATE_LOAD_EN
// to make DIV_LOAD restart the period at once instead of deferring to the next wrap.
module prog_clock_divider #(
    parameter int unsigned WIDTH   = 19,
    parameter int unsigned DEF_DIV = 262144
) (
    input logic                 CLK,
    input logic                 RST,
    prog_clock_divider_if.slave bus
);
    localparam logic [WIDTH-1:0] DEF_DIV_W = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV   = WIDTH'(2);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_active_q, div_active_d;
    logic             divided_clk_q, divided_clk_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] load_val;
    logic             wrap;

    // Divisors of 0 or 1 would break the square wave, so they are raised to 2.
    assign load_val = (bus.DIV_IN < MIN_DIV) ? MIN_DIV : bus.DIV_IN;
    assign wrap     = bus.ENABLE && (cnt_q == div_active_q - WIDTH'(1));

`ifdef CLKDIV_IMMEDIATE_LOAD_EN
    always_comb begin
        cnt_d         = cnt_q;
        div_active_d  = div_active_q;
        divided_clk_d = divided_clk_q;
        tick_d        = 1'b0;
        if (bus.DIV_LOAD) begin
            div_active_d  = load_val;
            cnt_d         = '0;
            divided_clk_d = 1'b0;
        end else if (bus.ENABLE) begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
            divided_clk_d = (cnt_d >= (div_active_d >> 1));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q         <= '0;
            div_active_q  <= DEF_DIV_W;
            divided_clk_q <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            div_active_q  <= div_active_d;
            divided_clk_q <= divided_clk_d;
            tick_q        <= tick_d;
        end
    end
`else
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;

    always_comb begin
        cnt_d         = cnt_q;
        div_active_d  = div_active_q;
        divided_clk_d = divided_clk_q;
        tick_d        = 1'b0;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        if (bus.DIV_LOAD) begin
            shadow_d  = load_val;
            pending_d = 1'b1;
        end
        if (bus.ENABLE) begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                // A load landing on the wrap edge itself takes effect right away.
                if (bus.DIV_LOAD) begin
                    div_active_d = load_val;
                    pending_d    = 1'b0;
                end else if (pending_q) begin
                    div_active_d = shadow_q;
                    pending_d    = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
            divided_clk_d = (cnt_d >= (div_active_d >> 1));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q         <= '0;
            div_active_q  <= DEF_DIV_W;
            shadow_q      <= DEF_DIV_W;
            pending_q     <= 1'b0;
            divided_clk_q <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            div_active_q  <= div_active_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            divided_clk_q <= divided_clk_d;
            tick_q        <= tick_d;
        end
    end
`endif

    assign bus.DIVIDEDCLK = divided_clk_q;
    assign bus.TICK       = tick_q;
    assign bus.DIV_ACTIVE = div_active_q;
endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: a small-default instance for the
// functional scenarios plus a default-parameter instance for reset values.
module tb_prog_clock_divider;
    localparam int unsigned WIDTH = 19;

    logic clk;
    logic rst;

    prog_clock_divider_if #(.WIDTH(WIDTH)) bus ();
    prog_clock_divider_if #(.WIDTH(WIDTH)) def_bus ();

    prog_clock_divider #(.WIDTH(WIDTH), .DEF_DIV(6)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    prog_clock_divider dut_def (
        .CLK (clk),
        .RST (rst),
        .bus (def_bus.slave)
    );

    int n_vec;
    int n_bad;
    logic def_tick_seen;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst) def_tick_seen <= 1'b0;
        else if (def_bus.TICK) def_tick_seen <= 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_tick(input string tag, input int exp);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.TICK && n < exp + 8);
        chk(tag, n, exp);
    endtask

    task automatic run_pattern(input string tag, input int n,
                               input logic [31:0] tick_exp, input logic [31:0] dclk_exp);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s_tick%0d", tag, i), bus.TICK, tick_exp[i]);
            chk($sformatf("%s_dclk%0d", tag, i), bus.DIVIDEDCLK, dclk_exp[i]);
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] val);
        bus.DIV_IN   = val;
        bus.DIV_LOAD = 1'b1;
        step();
        bus.DIV_LOAD = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.ENABLE = 1'b0;
        bus.DIV_IN = '0;
        bus.DIV_LOAD = 1'b0;
        def_bus.ENABLE = 1'b1;
        def_bus.DIV_IN = '0;
        def_bus.DIV_LOAD = 1'b0;

        // Reset values
        repeat (3) step();
        chk("rst_div", bus.DIV_ACTIVE, 6);
        chk("rst_dclk", bus.DIVIDEDCLK, 0);
        chk("rst_tick", bus.TICK, 0);
        chk("def_rst_div", def_bus.DIV_ACTIVE, 262144);
        chk("def_rst_dclk", def_bus.DIVIDEDCLK, 0);
        chk("def_rst_tick", def_bus.TICK, 0);

        // First period with D=6: tick after 6 edges, 3 low / 3 high
        rst = 1'b0;
        bus.ENABLE = 1'b1;
        run_pattern("first6", 6, 32'b100000, 32'b011100);

        // Load 4 mid-period: current period of 6 finishes first
        load(4);
        wait_tick("load4_wrap", 5);
        chk("load4_div", bus.DIV_ACTIVE, 4);
        run_pattern("d4", 8, 32'b10001000, 32'b01100110);

        // Odd divisor 5: 2 low, 3 high
        load(5);
        wait_tick("load5_wrap", 3);
        chk("load5_div", bus.DIV_ACTIVE, 5);
        run_pattern("d5", 10, 32'b1000010000, 32'b0111001110);

        // Clamp: 0 and 1 become 2
        load(0);
        wait_tick("load0_wrap", 4);
        chk("load0_div", bus.DIV_ACTIVE, 2);
        run_pattern("d2a", 4, 32'b1010, 32'b0101);
        load(1);
        wait_tick("load1_wrap", 1);
        chk("load1_div", bus.DIV_ACTIVE, 2);
        run_pattern("d2b", 4, 32'b1010, 32'b0101);

        // D=8, load 3 at CNT=2 then 6 at CNT=4: last load wins at the wrap
        load(8);
        wait_tick("load8_wrap", 1);
        chk("load8_div", bus.DIV_ACTIVE, 8);
        repeat (2) step();
        load(3);
        step();
        load(6);
        wait_tick("d8_finish", 3);
        chk("last_wins_div", bus.DIV_ACTIVE, 6);
        wait_tick("d6_period", 6);

        // Load coincident with the wrap edge applies at that wrap
        repeat (5) step();
        load(4);
        chk("coinc_tick", bus.TICK, 1);
        chk("coinc_div", bus.DIV_ACTIVE, 4);
        wait_tick("coinc_period", 4);

        // ENABLE low at CNT=1 for 10 cycles, with a load captured while frozen
        step();
        bus.ENABLE = 1'b0;
        load(7);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            chk($sformatf("frz_tick%0d", i), bus.TICK, 0);
            chk($sformatf("frz_dclk%0d", i), bus.DIVIDEDCLK, 0);
            chk($sformatf("frz_div%0d", i), bus.DIV_ACTIVE, 4);
        end
        bus.ENABLE = 1'b1;
        wait_tick("reen_tick", 3);
        chk("reen_div", bus.DIV_ACTIVE, 7);

        // Disable right on the tick: TICK must drop, counter holds at 0
        bus.ENABLE = 1'b0;
        step();
        chk("frz0_tick", bus.TICK, 0);
        chk("frz0_dclk", bus.DIVIDEDCLK, 0);
        step();
        bus.ENABLE = 1'b1;
        wait_tick("d7_period", 7);

        // Reset with a load pending (and a load during reset) discards it
        repeat (2) step();
        load(9);
        rst = 1'b1;
        load(9);
        rst = 1'b0;
        chk("rst2_div", bus.DIV_ACTIVE, 6);
        chk("rst2_tick", bus.TICK, 0);
        chk("rst2_dclk", bus.DIVIDEDCLK, 0);
        wait_tick("rst2_first", 6);
        chk("rst2_div_after", bus.DIV_ACTIVE, 6);
        wait_tick("rst2_second", 6);

        // Default instance still in its first 2^18-cycle period
        chk("def_div_end", def_bus.DIV_ACTIVE, 262144);
        chk("def_no_tick", def_tick_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
